// File: rtl/lpc_frame_buffer.sv
// Packs decoded LPC transactions into 8-byte frames in a ring buffer and
// exposes the oldest committed frame to the serial dump consumer.
//
// state | meaning
// IDLE  | waiting for lpc_latch, capture allowed when not full
// WRITE | streaming the captured frame into RAM, one byte per cycle
module lpc_frame_buffer #(
    parameter int AW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          lpc_latch,
    input  logic [3:0]    lpc_cyctype_dir,
    input  logic [31:0]   lpc_addr,
    input  logic [7:0]    lpc_data,
    input  logic [AW-1:0] read_addr,
    output logic [7:0]    read_data,
    output logic [AW-4:0] target_addr,
    output logic          read_empty,
    input  logic          read_done,
    output logic          overflow,
    output logic [7:0]    drop_count
);

    localparam int PW = AW - 3;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    seq_q, seq_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    cyc_q, cyc_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    snap_q, snap_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;
    logic          done_q;
    logic [7:0]    read_data_q;

    logic [7:0]    mem [0:(1<<AW)-1];

    logic [PW-1:0] wr_ptr_inc;
    logic          full;
    logic          empty;
    logic          drop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_byte;
    logic          release_frame;

    assign wr_ptr_inc    = wr_ptr_q + 1'b1;
    assign full          = (wr_ptr_inc == rd_ptr_q);
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign drop          = lpc_latch && ((state_q == WRITE) || full);
    assign release_frame = read_done && !done_q && !empty;
    assign wr_en         = (state_q == WRITE);
    assign wr_addr       = {wr_ptr_q, cnt_q};

    always_comb begin
        wr_byte = 8'h00;
        case (cnt_q)
            3'd0: wr_byte = {cyc_q, seq_q};
            3'd1: wr_byte = addr_q[31:24];
            3'd2: wr_byte = addr_q[23:16];
            3'd3: wr_byte = addr_q[15:8];
            3'd4: wr_byte = addr_q[7:0];
            3'd5: wr_byte = data_q;
            3'd6: wr_byte = snap_q;
            default: wr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        addr_d     = addr_q;
        data_d     = data_q;
        snap_d     = snap_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (lpc_latch && !full) begin
                    cyc_d   = lpc_cyctype_dir;
                    addr_d  = lpc_addr;
                    data_d  = lpc_data;
                    snap_d  = drop_q;
                    cnt_d   = 3'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    wr_ptr_d = wr_ptr_inc;
                    seq_d    = seq_q + 4'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Drops never stall capture; the counter just sticks at its maximum.
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hff) drop_d = drop_q + 8'd1;
        end

        if (release_frame) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            seq_q       <= 4'd0;
            cnt_q       <= 3'd0;
            cyc_q       <= 4'd0;
            addr_q      <= 32'd0;
            data_q      <= 8'd0;
            snap_q      <= 8'd0;
            overflow_q  <= 1'b0;
            drop_q      <= 8'd0;
            done_q      <= 1'b0;
            read_data_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            snap_q      <= snap_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            done_q      <= read_done;
            read_data_q <= mem[read_addr];
        end
    end

    // RAM has no reset; a same-address read this cycle sees the old byte.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_byte;
    end

    assign read_data   = read_data_q;
    assign target_addr = rd_ptr_q;
    assign read_empty  = empty;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;

endmodule

// File: doc/lpc_frame_buffer.md
Name: lpc_frame_buffer

Overview:
- Upstream stage of the serial dump path: captures decoded LPC transactions and packs each into an 8-byte frame in an internal ring buffer of 2^(AW-3) frames.
- Exposes the oldest unsent frame to the mem2serial stage through a frame index, a byte read port, an empty flag and a release strobe.
- Overflow is counted and flagged, never blocking the LPC side.

Parameters:
AW, 16, byte address width of the buffer RAM; depth 2^AW bytes = 2^(AW-3) frames

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
lpc_latch  input  1  one-cycle pulse: transaction fields valid this cycle
lpc_cyctype_dir  input  4  cycle type and direction code
lpc_addr  input  32  transaction address
lpc_data  input  8  transaction data byte
read_addr  input  AW  byte address from consumer ({frame index, byte offset})
read_data  output  8  RAM byte at read_addr, registered
target_addr  output  AW-3  frame index of oldest unsent frame (= read pointer)
read_empty  output  1  high when no committed unsent frame exists
read_done  input  1  consumer release; rising edge frees current frame
overflow  output  1  sticky: at least one transaction dropped since reset
drop_count  output  8  dropped transactions, saturating at 8'hff

Behaviour:
- Reset (reset low, asynchronous): wr_ptr=0, rd_ptr=0, seq=0, write FSM IDLE, read_data=0, read_empty=1, target_addr=0, overflow=0, drop_count=0, read_done edge register=0. RAM contents are not cleared.
- Frame layout, byte offset 0..7:
  - 0: {cyctype_dir, seq[3:0]}
  - 1-4: lpc_addr[31:24], [23:16], [15:8], [7:0]
  - 5: lpc_data
  - 6: drop_count snapshot at capture
  - 7: 8'h00
- Write FSM, states IDLE and WRITE:
  - IDLE + lpc_latch + not full: register all fields and the drop_count snapshot, set byte counter=0, go to WRITE.
  - WRITE: one byte per cycle at address {wr_ptr, counter}.
  - After byte 7 is written (8th WRITE cycle): wr_ptr += 1 (wraps modulo 2^(AW-3)), seq += 1 (4-bit wrap), return to IDLE.
  - The new frame becomes visible (read_empty may fall) in the cycle after the commit edge.
- Full: (wr_ptr + 1) == rd_ptr, modulo width. One slot always stays unused, so capacity is 2^(AW-3) - 1 frames.
- Drop: a transaction is dropped when lpc_latch arrives while full or while in WRITE.
  - Set overflow=1.
  - drop_count += 1, saturating at 8'hff.
  - wr_ptr, seq and RAM are unchanged.
- Read port: read_data <= RAM[read_addr] every clock (1-cycle latency), independent of the empty state.
  - Same-cycle write and read of the same address returns the old byte.
- Release: read_done is registered; a 0->1 transition with read_empty=0 gives rd_ptr += 1 (wraps).
  - A rising edge while empty is ignored.
  - A level held high causes no further releases.
- read_empty = (wr_ptr == rd_ptr), registered pointers. target_addr = rd_ptr.
- Commit and release on the same edge: both pointers update and the frame count is unchanged.
- Reset mid-WRITE: the partial frame is abandoned and never exposed (wr_ptr=0).

Test Plan:
- One lpc_latch (cyctype_dir=4'h2, addr=32'h0000_0080, data=8'h5a) -> read_empty falls 9 cycles later; read_addr 0..7 return 20,00,00,00,80,5a,00,00; target_addr=0.
- read_done 0->1 after the frame above -> rd_ptr=1, read_empty=1 next cycle; holding read_done high, then a second frame -> target_addr stays 1 until the next rising edge.
- lpc_latch 3 cycles after a prior latch (FSM in WRITE) -> second transaction dropped, overflow=1, drop_count=1; the next accepted frame has byte6=01 and byte0 low nibble=1.
- AW=5 (4 frames), 4 transactions with no release -> 3 stored, 4th dropped (drop_count=1); release all 3 -> target_addr walks 0,1,2 then read_empty=1; a new frame lands at index 3, then index 0 (wrap).
- 300 drops while full -> drop_count saturates at ff.
- Reset asserted during the 4th WRITE cycle -> immediately read_empty=1, overflow=0, drop_count=0; after release, normal capture resumes at frame 0 with seq=0.
